// File: rtl/mem_copy_engine.sv
// Block-copy engine for the single-port data memory. Once started it moves
// a contiguous, strictly ascending run of words from a source region to a
// destination region: one read cycle then one write cycle per word. The
// memory port is shared with the CPU; a low mem_grant stalls the engine in
// place with all of its outputs held steady.
//
// Handshake: the engine raises mem_req in READ and WRITE and owns the port
// only in a cycle where mem_grant is also high. A cycle with mem_req=1 and
// mem_grant=0 has no effect on engine state or memory, and mem_write is
// gated by mem_grant so a write never reaches memory without a grant.
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_copied,
    input  logic                  mem_grant,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0] r_data_buf;
    logic [LEN_WIDTH-1:0]  r_words_copied;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_req;

    // Control FSM: pointer/counter datapath plus registered status outputs
    // that are loaded together with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_src_ptr      <= '0;
            r_dst_ptr      <= '0;
            r_remaining    <= '0;
            r_data_buf     <= '0;
            r_words_copied <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_mem_req      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr      <= src_addr;
                        r_dst_ptr      <= dst_addr;
                        r_remaining    <= length;
                        r_words_copied <= '0;
                        r_busy         <= 1'b1;
                        if (length != '0) begin
                            r_state   <= S_READ;
                            r_mem_req <= 1'b1;
                        end else begin
                            // Zero-length copy: report completion, touch no memory.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // Read data is asynchronous, so it is valid in the same
                    // cycle the source address is presented.
                    if (mem_grant) begin
                        r_data_buf <= mem_read_data;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_grant) begin
                        // Pointers wrap naturally modulo 2^ADDR_WIDTH.
                        r_src_ptr      <= r_src_ptr + ADDR_WIDTH'(1);
                        r_dst_ptr      <= r_dst_ptr + ADDR_WIDTH'(1);
                        r_remaining    <= r_remaining - LEN_WIDTH'(1);
                        r_words_copied <= r_words_copied + LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state   <= S_DONE;
                            r_mem_req <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Memory port drive: address/data selected by state, write gated by grant.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        case (r_state)
            S_READ: begin
                mem_address = r_src_ptr;
            end
            S_WRITE: begin
                mem_address    = r_dst_ptr;
                mem_write_data = r_data_buf;
                mem_write      = mem_grant;
            end
            default: begin
                mem_address    = '0;
                mem_write_data = '0;
                mem_write      = 1'b0;
            end
        endcase
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem_req      = r_mem_req;
    assign words_copied = r_words_copied;
    assign dbg_state    = r_state;

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator driving the single-port `data_memory` interface (address, write_data, mem_write, asynchronous read_data). It sits beside the CPU datapath and, once started, moves a contiguous run of 16-bit words from a source region to a destination region, one read and one write per word. It shares the memory port with the CPU through a grant input and reports busy/done status back to the control unit.

## Interface
- `ADDR_WIDTH`, 16, width of memory addresses and address pointers.
- `DATA_WIDTH`, 16, memory word width.
- `LEN_WIDTH`, 16, width of the transfer length and word counter.

- `clk`  input  1  system clock, all state updates on rising edge.
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low.
- `start`  input  1  start request, sampled only in IDLE.
- `src_addr`  input  ADDR_WIDTH  first source word address, latched on accepted start.
- `dst_addr`  input  ADDR_WIDTH  first destination word address, latched on accepted start.
- `length`  input  LEN_WIDTH  number of words to copy, latched on accepted start.
- `busy`  output  1  high in READ, WRITE and DONE.
- `done`  output  1  one-cycle pulse in DONE.
- `words_copied`  output  LEN_WIDTH  count of words written in current/last transfer.
- `mem_grant`  input  1  port owned by engine this cycle; low stalls engine.
- `mem_req`  output  1  engine wants the port (high in READ and WRITE).
- `mem_address`  output  ADDR_WIDTH  memory address.
- `mem_write_data`  output  DATA_WIDTH  memory write data.
- `mem_write`  output  1  memory write enable.
- `mem_read_data`  input  DATA_WIDTH  asynchronous read data from memory.

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: src_ptr, dst_ptr, remaining, data_buf, words_copied.
- IDLE: start=1 → latch pointers/length, clear words_copied; length≠0 → READ, length=0 → DONE. start=0 → stay.
- READ: mem_req=1, mem_address=src_ptr, mem_write=0. mem_grant=1 → data_buf<=mem_read_data, → WRITE. mem_grant=0 → hold.
- WRITE: mem_req=1, mem_address=dst_ptr, mem_write_data=data_buf, mem_write=mem_grant (combinational; no write without grant). mem_grant=1 → src_ptr+1, dst_ptr+1, remaining−1, words_copied+1; remaining was 1 → DONE, else → READ. mem_grant=0 → hold.
- DONE: done=1 for exactly one cycle, → IDLE.
- IDLE/DONE outputs: mem_req=0, mem_write=0, mem_address=0, mem_write_data=0.
- Pointer arithmetic modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000. Addresses beyond the physical memory depth are caller's responsibility.
- Copy is strictly ascending. Overlap with dst>src inside source range replicates data (forward-copy semantics); defined, not an error.
- start while busy (READ/WRITE/DONE) ignored; inputs not re-sampled.
- words_copied holds final value in IDLE until next accepted start.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, mem_req=0, mem_write=0, mem_address=0, mem_write_data=0, words_copied=0, data_buf=0. Reset mid-transfer aborts; writes already committed stay, no further writes.
- start accepted at edge E0; READ visible cycle after E0.
- With continuous grant: 2 cycles per word; N words → done pulse in cycle 2N+1 after E0, busy high for 2N+1 cycles.
- length=0: DONE in cycle 1, done pulse, no memory access, words_copied=0.
- Each cycle with mem_grant=0 in READ/WRITE adds exactly one cycle latency; outputs stable while stalled.
- Read data captured same edge address is presented (memory read is asynchronous).
- Next start accepted earliest in IDLE cycle after DONE.

## Test plan
- Reset: preload mem[0x10..0x13]=0xA0A0..0xA0A3; start src=0x10,dst=0x40,len=4, grant=1 → mem[0x40..0x43]=0xA0A0..0xA0A3, done pulse at cycle 9, words_copied=4, exactly 4 mem_write cycles.
- len=0, src=0x05,dst=0x06 → done in cycle 1, mem_write never asserted, words_copied=0.
- len=3 with mem_grant toggling 1,0,1,0… → same final memory contents, done at cycle 13, mem_write never high while grant=0, mem_address held during stalls.
- Wrap: src=0x03FE→0xFFFE region mapped test, dst=0xFFFF,len=2 → second write at mem_address=0x0000.
- Overlap: mem[0x20]=0x1111,mem[0x21]=0x2222, src=0x20,dst=0x21,len=2 → mem[0x21]=0x1111, mem[0x22]=0x1111.
- Pulse start=1 during WRITE of a len=4 copy with different src/dst → ignored, original transfer completes; assert rst_n=0 mid-transfer after 2 words → outputs to reset values immediately, words 3–4 never written.
